// File: rtl/ula_seq_if.sv
// rtl/ula_seq_if.sv - request/result handshake bundle for the sequential ALU
interface ula_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       OpALU;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, OpALU, funct, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, err
    );

    modport slave (
        input  in_valid, OpALU, funct, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, zero, err
    );
endinterface

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU with optional shift-add multiplier (macro ULA_SEQ_MULT_EN)
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    ula_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MUL, OP_UND
    } op_t;

    // Reject parameter combinations the datapath cannot support.
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("ula_seq: WIDTH must be within 8..64");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("ula_seq: CNT_W too narrow to count WIDTH multiply steps");
    end

    state_t           state_q, state_d;
    op_t              op_dec;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;

`ifdef ULA_SEQ_MULT_EN
    logic [WIDTH-1:0] result_hi_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             mul_last;
`endif

    // A request is taken only while idle; busy-time requests are dropped.
    assign accept = bus.in_valid && (state_q == S_IDLE);

    // Opcode decode from the live request fields (only used at accept).
    always_comb begin
        op_dec = OP_UND;
        unique case (bus.OpALU)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b100111: op_dec = OP_NOR;
                    6'b101010: op_dec = OP_SLT;
`ifdef ULA_SEQ_MULT_EN
                    6'b011000: op_dec = OP_MUL;
`endif
                    default:   op_dec = OP_UND;
                endcase
            end
            default: op_dec = OP_UND;
        endcase
    end

    // Single-cycle ALU result; undefined and multiply yield zero here.
    always_comb begin
        alu_res = '0;
        case (op_dec)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;
        endcase
    end

`ifdef ULA_SEQ_MULT_EN
    // One shift-add step: conditionally add the multiplicand to the high half,
    // then shift the {carry, hi, lo} product register right by one.
    always_comb begin
        step_sum = {1'b0, result_hi_q} + (result_q[0] ? {1'b0, mcand_q} : '0);
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], result_q[WIDTH-1:1]};
        mul_last = (cnt_q == CNT_W'(WIDTH));
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef ULA_SEQ_MULT_EN
                    state_d = (op_dec == OP_MUL) ? S_MUL : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_MUL: begin
`ifdef ULA_SEQ_MULT_EN
                if (mul_last) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    // Result datapath: load at accept, iterate during MUL, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ULA_SEQ_MULT_EN
            result_hi_q <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else if (accept) begin
`ifdef ULA_SEQ_MULT_EN
            if (op_dec == OP_MUL) begin
                mcand_q  <= bus.a;
                mplier_q <= bus.b;
                cnt_q    <= '0;
            end else
`endif
            begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                err_q    <= (op_dec == OP_UND);
`ifdef ULA_SEQ_MULT_EN
                result_hi_q <= '0;
`endif
            end
        end
`ifdef ULA_SEQ_MULT_EN
        else if (state_q == S_MUL) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == '0) begin
                // First MUL cycle seeds the product register from the captured operands.
                result_hi_q <= '0;
                result_q    <= mplier_q;
            end else begin
                result_hi_q <= step_hi;
                result_q    <= step_lo;
                if (mul_last) begin
                    zero_q <= (step_lo == '0);
                    err_q  <= 1'b0;
                end
            end
        end
`endif
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
`ifdef ULA_SEQ_MULT_EN
    assign bus.result_hi = result_hi_q;
`else
    assign bus.result_hi = '0;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - self-checking bench for ula_seq (honours ULA_SEQ_MULT_EN)
module tb_ula_seq;
    localparam int W = 32;

`ifdef ULA_SEQ_MULT_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(W)) bus ();
    ula_seq #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        e;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        e;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v, input int hold, input string nm);
        int   cyc;
        logic busy_ok;
        exp_t e;
        cyc = 0;
        @(negedge clk);
        while (!bus.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.OpALU    = v.op;
        bus.funct    = v.fn;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{v.r, v.h, v.z, v.e});
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.OpALU    = 2'($urandom);
        bus.funct    = 6'($urandom);
        cyc     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
        end while (!bus.out_valid && cyc < 200);
        chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        e = sb.pop_front();
        if (!bus.out_valid) return;
        chk({nm, "_latency"}, 64'(cyc), 64'(v.lat));
        chk({nm, "_busy_not_ready"}, 64'(busy_ok), 64'd1);
        chk({nm, "_result"}, 64'(bus.result), 64'(e.r));
        chk({nm, "_result_hi"}, 64'(bus.result_hi), 64'(e.h));
        chk({nm, "_zero"}, 64'(bus.zero), 64'(e.z));
        chk({nm, "_err"}, 64'(bus.err), 64'(e.e));
        chk({nm, "_done_not_ready"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.OpALU    = 2'($urandom);
            bus.funct    = 6'($urandom);
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({nm, "_hold_result"}, 64'(bus.result), 64'(e.r));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "_release_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, "_release_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int   seen;
        vec_t v;

        vecs.push_back('{2'b10, 6'b100000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{2'b00, 6'b000000, 32'd5, 32'd7, 32'd12, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b01, 6'b111111, 32'd3, 32'd5, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b100010, 32'd10, 32'd10, 32'h0, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b100111, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b101010, 32'hFFFFFFFE, 32'd3, 32'd1, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b101010, 32'd3, 32'hFFFFFFFE, 32'd0, 32'h0, 1'b1, 1'b0, 1});
        vecs.push_back('{2'b11, 6'b100000, 32'd9, 32'd4, 32'h0, 32'h0, 1'b1, 1'b1, 1});
        vecs.push_back('{2'b10, 6'b111111, 32'd9, 32'd4, 32'h0, 32'h0, 1'b1, 1'b1, 1});
`ifdef ULA_SEQ_MULT_EN
        vecs.push_back('{2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33});
        vecs.push_back('{2'b10, 6'b011000, 32'h12345678, 32'd9, 32'hA3D70A38, 32'h0, 1'b0, 1'b0, 33});
        vecs.push_back('{2'b10, 6'b011000, 32'h80000000, 32'd2, 32'h0, 32'h1, 1'b1, 1'b0, 33});
`else
        vecs.push_back('{2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1, 1});
        vecs.push_back('{2'b10, 6'b011000, 32'h12345678, 32'd9, 32'h0, 32'h0, 1'b1, 1'b1, 1});
`endif

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.OpALU     = 2'b00;
        bus.funct     = 6'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_result_hi", 64'(bus.result_hi), 64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) apply(vecs[i], 0, $sformatf("v%0d", i));

        // Backpressure for five cycles with inputs toggling.
        apply(vecs[1], 5, "bp");

        // Reset wins over a simultaneous accept.
        @(negedge clk);
        reset        = 1'b1;
        bus.OpALU    = 2'b00;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_prio_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset mid-operation aborts it without presenting a result.
        @(negedge clk);
        bus.OpALU    = 2'b10;
        bus.funct    = MUL_ON ? 6'b011000 : 6'b100000;
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 32'hFFFFFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_result_hi", 64'(bus.result_hi), 64'd0);
        chk("abort_zero", 64'(bus.zero), 64'd0);
        chk("abort_err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        v = '{2'b00, 6'b000000, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0, 1};
        apply(v, 0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 Parameter CNT_W, default 6, multiply step-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 OpALU  input  2  main-control ALU opcode.
REQ-008 funct  input  6  R-type function field.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  result, low half for multiply.
REQ-014 result_hi  output  WIDTH  high half of multiply product; 0 for other ops.
REQ-015 zero  output  1  result == 0.
REQ-016 err  output  1  request decoded as undefined.

Function
REQ-017 Decode: OpALU 00 -> add; 01 -> sub; 10 -> by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed, result 1/0), 011000 mult (unsigned); OpALU 11 or other funct -> undefined.
REQ-018 FSM states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 Accept occurs on an edge with in_valid=1 and in_ready=1; a, b, OpALU, funct SHALL be captured at accept; later changes to inputs SHALL not affect the operation.
REQ-020 Single-cycle ops and undefined ops: IDLE -> DONE at accept; out_valid SHALL be 1 in the cycle after accept (latency 1).
REQ-021 Undefined op: result=0, result_hi=0, zero=1, err=1; otherwise err=0.
REQ-022 Add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-023 mult: IDLE -> MUL at accept; shift-add one multiplier bit per cycle for exactly WIDTH cycles; MUL -> DONE on last step; out_valid SHALL rise WIDTH+1 cycles after accept.
REQ-024 mult product SHALL be full 2*WIDTH bits: result_hi = upper WIDTH bits, result = lower WIDTH bits; zero reflects result only.
REQ-025 DONE: outputs held stable while out_valid=1 and out_ready=0 (backpressure, any duration).
REQ-026 DONE with out_ready=1: DONE -> IDLE; out_valid=0 next cycle; new request accepted no earlier than the cycle after (no overlap, max one op in flight).
REQ-027 in_valid while busy (MUL/DONE) SHALL be ignored, not queued.
REQ-028 result, result_hi, zero, err SHALL be registered; outside DONE their values are don't-care for the consumer but SHALL not be X after reset.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, clear step counter, set out_valid=0, result=0, result_hi=0, zero=0, err=0; in_ready=1 from the next cycle.
REQ-030 reset asserted mid-MUL or in DONE SHALL abort the operation with no result presented; reset has priority over accept in the same cycle.

Configuration
REQ-031 Macro ULA_SEQ_MULT_EN: defined -> multiplier datapath, MUL state and counter compiled in, behaviour per REQ-023/024.
REQ-032 ULA_SEQ_MULT_EN undefined -> no multiplier logic; funct 011000 decoded as undefined (REQ-021, latency 1); result_hi tied 0.

Verification
REQ-033 WIDTH=32, OpALU=10 funct=100000, a=0xFFFFFFFF, b=1 -> out_valid next cycle, result=0, zero=1, err=0.
REQ-034 OpALU=10 funct=101010, a=0xFFFFFFFE (-2), b=3 -> result=1; swap operands -> result=0.
REQ-035 ULA_SEQ_MULT_EN defined, mult a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result_hi=0xFFFFFFFE, result=0x00000001; in_ready=0 throughout.
REQ-036 out_ready=0 for 5 cycles in DONE with inputs toggling -> result unchanged, out_valid=1; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 reset pulsed at cycle 10 of a mult -> out_valid never asserts for it, all outputs 0, next add (a=2,b=3) returns 5 with latency 1.
REQ-038 OpALU=11 any funct, and (macro undefined) funct=011000 -> result=0, zero=1, err=1, latency 1.
